// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: 4-digit common-anode seven-segment scan driver with symbol decode and 1 Hz blink.
// Optional SSD_ANTIGHOST_EN blanks the anodes for GAP_CYCLES at the start of every slot.
module ssd_scan_driver #(
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_HALF = 50000000,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] code,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic [1:0]    dig_idx, nxt_idx;
  logic          blink_phase, started, wrap, dark;
  logic [4:0]    sym;
  logic [3:0]    an_lit;
  logic [6:0]    seg_nxt;
  function automatic logic [6:0] dec(input logic [4:0] s);
    logic [6:0] r;
    r = 7'h7F;
    case (s)
      5'h00: r = 7'h40; 5'h01: r = 7'h79; 5'h02: r = 7'h24; 5'h03: r = 7'h30;
      5'h04: r = 7'h19; 5'h05: r = 7'h12; 5'h06: r = 7'h02; 5'h07: r = 7'h78;
      5'h08: r = 7'h00; 5'h09: r = 7'h10; 5'h0A: r = 7'h08; 5'h0B: r = 7'h03;
      5'h0C: r = 7'h46; 5'h0D: r = 7'h21; 5'h0E: r = 7'h06; 5'h0F: r = 7'h0E;
      5'h11: r = 7'h3F; 5'h12: r = 7'h47; 5'h13: r = 7'h46; 5'h14: r = 7'h0C;
      5'h15: r = 7'h41; 5'h16: r = 7'h2B; 5'h17: r = 7'h2F;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction
  // The first edge after reset acts as a slot boundary so scanning starts at digit 0.
  always_comb begin
    wrap    = !started || scan_cnt == SW'(SCAN_DIV - 1);
    nxt_idx = dig_idx + 2'd1;
    sym     = nxt_idx == 2'd0 ? code[4:0] : nxt_idx == 2'd1 ? code[9:5] :
              nxt_idx == 2'd2 ? code[14:10] : code[19:15];
    dark    = blink_mask[nxt_idx] & ~blink_phase;
    seg_nxt = dark ? 7'h7F : dec(sym);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started     <= 1'b0;
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      dig_idx     <= 2'd3;
      blink_phase <= 1'b1;
      an_lit      <= 4'hF;
      seg         <= 7'h7F;
    end else begin
      started <= 1'b1;
      if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
      if (wrap) begin
        scan_cnt <= '0;
        dig_idx  <= nxt_idx;
        an_lit   <= dark ? 4'hF : ~(4'b0001 << nxt_idx);
        seg      <= seg_nxt;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end
`ifdef SSD_ANTIGHOST_EN
  assign an = scan_cnt < SW'(GAP_CYCLES) ? 4'hF : an_lit;
`else
  assign an = an_lit;
`endif
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed plus randomized checks of ssd_scan_driver against a slot/arithmetic model.
module tb_ssd_scan_driver;
  localparam int SD = 4, BH = 32, GC = 1;
`ifdef SSD_ANTIGHOST_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  localparam logic [6:0] TBL [32] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
    7'h7F, 7'h3F, 7'h47, 7'h46, 7'h0C, 7'h41, 7'h2B, 7'h2F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic clk = 1'b0, rst = 1'b1;
  logic [19:0] code = '0;
  logic [3:0] blink_mask = '0, an;
  logic [6:0] seg;
  int vecs = 0, errs = 0, n = 0;
  bit in_rst = 1'b1;
  logic [19:0] cap_code;
  logic [3:0] cap_mask;
  bit cap_phase;

  ssd_scan_driver #(.SCAN_DIV(SD), .BLINK_HALF(BH), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .code(code), .blink_mask(blink_mask), .an(an), .seg(seg));

  always #5 clk = ~clk;

  task automatic check();
    logic [3:0] ea;
    logic [6:0] es;
    logic [4:0] s;
    int d, pos;
    bit drk;
    if (in_rst || n == 0) begin
      ea = 4'hF;
      es = 7'h7F;
    end else begin
      pos = (n - 1) % SD;
      d   = ((n - 1) / SD) % 4;
      s   = 5'(cap_code >> (5 * d));
      drk = cap_mask[d] && !cap_phase;
      es  = drk ? 7'h7F : TBL[s];
      ea  = drk ? 4'hF : (GAP && pos < GC) ? 4'hF : ~(4'b0001 << d);
    end
    vecs++;
    assert (an === ea) else begin
      errs++;
      $error("FAIL an n=%0d observed=%b expected=%b", n, an, ea);
    end
    vecs++;
    assert (seg === es) else begin
      errs++;
      $error("FAIL seg n=%0d observed=%h expected=%h", n, seg, es);
    end
  endtask

  // One clock: the model samples inputs at slot-boundary edges, then outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    if (!in_rst) begin
      n++;
      if ((n - 1) % SD == 0) begin
        cap_code  = code;
        cap_mask  = blink_mask;
        cap_phase = ((n - 1) / BH) % 2 == 0;
      end
    end
    #1;
    check();
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic release_rst();
    #3;
    rst = 1'b0;
    in_rst = 1'b0;
    n = 0;
    #1;
    check();
  endtask

  initial begin
    ticks(3);
    release_rst();
    code = {5'h13, 5'h12, 5'h05, 5'h0D};
    ticks(2 * 4 * SD);
    code = {5'h11, 5'h00, 5'h10, 5'h10};
    ticks(4 * SD);
    code = 20'hFFFFF;
    ticks(4 * SD);
    code = '0;
    blink_mask = 4'b1000;
    ticks(5 * BH);
    blink_mask = 4'b0000;
    while (((n - 1) % (4 * SD)) != 1) tick();
    code[4:0] = 5'h05;
    ticks(4 * SD + 4);
    #2;
    rst = 1'b1;
    in_rst = 1'b1;
    #1;
    check();
    ticks(2);
    release_rst();
    ticks(3 * SD);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) code = 20'($urandom);
      if ($urandom_range(0, 7) == 0) blink_mask = 4'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
